// File: rtl/nibble_sort_ctrl_pkg.sv
// rtl/nibble_sort_ctrl_pkg.sv - shared types and sizes for the nibble sorter
package nibble_sort_ctrl_pkg;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 4;
    localparam int SWAP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sort_ctrl_cmp.sv
// rtl/nibble_sort_ctrl_cmp.sv - unsigned nibble comparator, exactly one flag high
module cmp_nibble
    import nibble_sort_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt,
    output logic              eq,
    output logic              lt
);

    // Pure combinational magnitude compare.
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/nibble_sort_ctrl.sv
// rtl/nibble_sort_ctrl.sv - 4-entry bubble sorter with load, sort and drain phases
module nibble_sort_ctrl
    import nibble_sort_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              done,
    output logic [SWAP_W-1:0] swap_count
);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [2:0]        count;
    logic [1:0]        rd_ptr;
    logic [1:0]        idx;
    logic [1:0]        idx_nx;
    logic [1:0]        pass;
    logic              pass_swapped;
    logic              gt;
    logic              eq;
    logic              lt;
    logic              in_order;

    // The single comparator always looks at the pair selected by idx.
    cmp_nibble u_cmp (
        .a  (mem[idx]),
        .b  (mem[idx_nx]),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    // Pair pointer and "current pair needs no swap" decode.
    always_comb begin
        idx_nx   = idx + 2'd1;
        in_order = lt | eq;
    end

    // Handshake outputs derived from state; out_data is zero outside DRAIN.
    always_comb begin
        load_ready = (state == IDLE) && (count < 3'(DEPTH));
        out_data   = out_valid ? mem[rd_ptr] : '0;
    end

    // Main controller: buffer fill, one compare per cycle, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            rd_ptr       <= '0;
            idx          <= '0;
            pass         <= '0;
            pass_swapped <= 1'b0;
            swap_count   <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A load wins over start; start only counts with a full buffer.
                    if (load_valid && load_ready) begin
                        mem[count[1:0]] <= load_data;
                        count           <= count + 3'd1;
                    end else if (start && (count == 3'(DEPTH))) begin
                        state        <= SORT;
                        busy         <= 1'b1;
                        swap_count   <= '0;
                        pass         <= '0;
                        idx          <= '0;
                        pass_swapped <= 1'b0;
                    end
                end
                SORT: begin
                    if (gt) begin
                        mem[idx]    <= mem[idx_nx];
                        mem[idx_nx] <= mem[idx];
                        swap_count  <= swap_count + 3'd1;
                    end
                    if (idx == 2'd2) begin
                        // Stop on a clean pass or after the third pass.
                        if ((!pass_swapped && in_order) || (pass == 2'd2)) begin
                            state     <= DRAIN;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            rd_ptr    <= '0;
                        end else begin
                            pass         <= pass + 2'd1;
                            idx          <= '0;
                            pass_swapped <= 1'b0;
                        end
                    end else begin
                        idx          <= idx_nx;
                        pass_swapped <= pass_swapped | gt;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_ptr == 2'(DEPTH - 1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            count     <= '0;
                            rd_ptr    <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// tb/tb_nibble_sort_ctrl.sv - self-checking bench for nibble_sort_ctrl
module tb_nibble_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_ready;
    logic       start;
    logic       busy;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       done;
    logic [2:0] swap_count;

    int checks = 0;
    int errors = 0;

    nibble_sort_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .done       (done),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    // Element k of a packed vector lives in bits [4k+3:4k].
    function automatic logic [15:0] pack4(input logic [3:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    // Reference: bubble sort with early exit on a clean pass, at most 3 passes.
    task automatic model(input logic [15:0] v, output logic [15:0] sorted,
                         output int swaps, output int passes);
        int a[4];
        int t;
        bit any;
        for (int k = 0; k < 4; k++) a[k] = int'(v[k*4 +: 4]);
        swaps  = 0;
        passes = 0;
        for (int p = 0; p < 3; p++) begin
            any = 0;
            passes++;
            for (int i = 0; i < 3; i++) begin
                if (a[i] > a[i+1]) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    swaps++;
                    any = 1;
                end
            end
            if (!any) break;
        end
        sorted = '0;
        for (int k = 0; k < 4; k++) sorted[k*4 +: 4] = 4'(a[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_one(input logic [3:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] v);
        for (int k = 0; k < 4; k++) load_one(v[k*4 +: 4]);
    endtask

    // Start, count busy cycles, optionally stall, drain and count done pulses.
    task automatic sort_and_drain(input int stall, output int busy_cycles,
                                  output logic [15:0] got, output int dcnt,
                                  output logic [2:0] swaps, output bit hold_ok,
                                  output logic [3:0] first);
        int n;
        int guard;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        dcnt = 0;
        while (busy && busy_cycles < 40) begin
            busy_cycles++;
            tick();
        end
        hold_ok = 1'b1;
        first   = out_data;
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            if (!out_valid || out_data !== first) hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        n = 0;
        guard = 0;
        got = '0;
        while (n < 4 && guard < 20) begin
            if (out_valid) begin
                got[n*4 +: 4] = out_data;
                n++;
            end
            tick();
            guard++;
            if (done) dcnt++;
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            if (done) dcnt++;
        end
        swaps = swap_count;
    endtask

    task automatic run_case(input string name, input logic [15:0] v, input int stall);
        logic [15:0] exp_sorted;
        int          exp_swaps;
        int          exp_passes;
        int          bc;
        logic [15:0] got;
        int          dcnt;
        logic [2:0]  sw;
        bit          hold_ok;
        logic [3:0]  first;
        model(v, exp_sorted, exp_swaps, exp_passes);
        load_all(v);
        sort_and_drain(stall, bc, got, dcnt, sw, hold_ok, first);
        checks++;
        if (got !== exp_sorted) begin
            errors++;
            $display("FAIL %s order: got %h expected %h", name, got, exp_sorted);
        end
        checks++;
        if (bc != 3 * exp_passes) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, 3 * exp_passes);
        end
        checks++;
        if (sw !== 3'(exp_swaps)) begin
            errors++;
            $display("FAIL %s swap_count: got %0d expected %0d", name, sw, exp_swaps);
        end
        checks++;
        if (dcnt != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, dcnt);
        end
        if (stall > 0) begin
            checks++;
            if (!hold_ok || first !== exp_sorted[3:0]) begin
                errors++;
                $display("FAIL %s stall_hold: ok=%0d first=%h expected %h", name, hold_ok, first, exp_sorted[3:0]);
            end
        end
        checks++;
        if (load_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_idle: load_ready=%b busy=%b expected 1/0", name, load_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        checks++;
        if ({busy, out_valid, done, out_data, swap_count} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b ov=%b done=%b data=%h sc=%0d expected all 0",
                     busy, out_valid, done, out_data, swap_count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_load_ready: got %b expected 1", load_ready);
        end
    endtask

    task automatic test_directed();
        run_case("vec_5ac3", pack4(4'h5, 4'hA, 4'hC, 4'h3), 0);
        run_case("vec_1234", pack4(4'h1, 4'h2, 4'h3, 4'h4), 0);
        run_case("vec_f840", pack4(4'hF, 4'h8, 4'h4, 4'h0), 0);
        run_case("vec_cc33_stall", pack4(4'hC, 4'hC, 4'h3, 4'h3), 5);
    endtask

    task automatic test_start_ignored();
        load_one(4'h9);
        load_one(4'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_at_count2: busy=%b load_ready=%b expected 0/1", busy, load_ready);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_sort();
        int dcnt;
        load_all(pack4(4'hF, 4'h8, 4'h4, 4'h0));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sort: busy=%b load_ready=%b ov=%b expected 0/1/0", busy, load_ready, out_valid);
        end
        #2;
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy || out_valid) dcnt++;
        end
        checks++;
        if (dcnt != 0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_sort_after: activity=%0d load_ready=%b expected 0/1", dcnt, load_ready);
        end
    endtask

    task automatic test_load_start_same();
        load_one(4'hB);
        load_one(4'h2);
        load_one(4'hE);
        load_valid = 1'b1;
        load_data  = 4'h7;
        start      = 1'b1;
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_start_same: busy=%b load_ready=%b expected 0/0", busy, load_ready);
        end
        begin
            logic [15:0] exp_sorted;
            int es, ep, bc, dcnt;
            logic [15:0] got;
            logic [2:0] sw;
            bit hold_ok;
            logic [3:0] first;
            model(pack4(4'hB, 4'h2, 4'hE, 4'h7), exp_sorted, es, ep);
            sort_and_drain(0, bc, got, dcnt, sw, hold_ok, first);
            checks++;
            if (got !== exp_sorted || sw !== 3'(es) || dcnt != 1) begin
                errors++;
                $display("FAIL load_start_later_sort: got %h sc=%0d done=%0d expected %h sc=%0d done=1",
                         got, sw, dcnt, exp_sorted, es);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int r = 0; r < 20; r++) begin
            v = 16'($urandom);
            run_case("random", v, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_sort();
        test_load_start_same();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
